stream_to_array: RTL and testbench

- Writer-side companion to the array-reading kernels: accepts a valid/ready stream of words and writes them into the bram_2p array, addresses 0..n-1.
- Uses the same write-port signals that the kernels leave unused, so a testbench or top can fill an array before a reader kernel runs on it.
- Uses the same start/finish kernel handshake as the reader kernels.
- Also returns a running 32-bit checksum of the written words, so a read-back sum can be cross-checked against it.

---
 rtl/stream_to_array.sv | 113 +++++++++++
 tb/tb_stream_to_array.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_to_array.sv
// stream_to_array: fills a two-port array from a valid/ready word stream.
// Words land at addresses 0..n-1 in arrival order. A running checksum of
// the accepted words is returned on res. The start/finish handshake matches
// the array-reader kernels, so a fill can run ahead of a reader on the same
// array.
//
// Handshake: a word transfers on every rising clk edge where
// in_valid && in_ready. in_ready is high only in WRITE and does not depend
// on in_valid. The producer must hold in_data stable while in_valid is high
// and in_ready is low. The array write strobe is that same transfer
// condition, so the array captures the word on the transfer edge.
module stream_to_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              finish,
  input  logic [ADDR_W-1:0] n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] res,
  output logic              arr_clk,
  output logic              arr_read_en,
  output logic [ADDR_W-1:0] arr_read_addr,
  input  logic [DATA_W-1:0] arr_read_val,
  output logic              arr_write_en,
  output logic [ADDR_W-1:0] arr_write_addr,
  output logic [DATA_W-1:0] arr_write_val
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] cnt;
  logic              hs;
  logic              last;

  // The read port belongs to the reader kernels; this block only writes.
  logic unused_read_val;
  assign unused_read_val = ^arr_read_val;

  assign arr_clk       = clk;
  assign arr_read_en   = 1'b0;
  assign arr_read_addr = '0;

  // Stream acceptance and array write strobe come straight from state and
  // in_valid, so each word is written on the edge that accepts it.
  always_comb begin
    in_ready       = (state == WRITE);
    hs             = in_valid && (state == WRITE);
    last           = (idx == (cnt - ONE));
    arr_write_en   = hs;
    arr_write_addr = idx;
    arr_write_val  = in_data;
  end

  // Fill sequencing: latch n on start, count words into the array,
  // then pulse finish for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      res    <= '0;
      finish <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt <= n;
            idx <= '0;
            res <= '0;
            if (n == '0) begin
              // Empty fill: go straight to the finish pulse.
              state  <= DONE;
              finish <= 1'b1;
            end else begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          if (hs) begin
            idx <= idx + ONE;
            res <= res + in_data;
            if (last) begin
              state  <= DONE;
              finish <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_to_array.sv
// Directed testbench for stream_to_array. A behavioural array model stands
// in for the two-port BRAM and captures every write strobe.
module tb_stream_to_array;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          finish;
  logic [AW-1:0] n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] res;
  logic          arr_clk;
  logic          arr_read_en;
  logic [AW-1:0] arr_read_addr;
  logic [DW-1:0] arr_read_val;
  logic          arr_write_en;
  logic [AW-1:0] arr_write_addr;
  logic [DW-1:0] arr_write_val;

  int vectors;
  int miscompares;

  logic [DW-1:0] mem [0:1023];

  stream_to_array #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .finish         (finish),
    .n              (n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .res            (res),
    .arr_clk        (arr_clk),
    .arr_read_en    (arr_read_en),
    .arr_read_addr  (arr_read_addr),
    .arr_read_val   (arr_read_val),
    .arr_write_en   (arr_write_en),
    .arr_write_addr (arr_write_addr),
    .arr_write_val  (arr_write_val)
  );

  // Clock and array model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge arr_clk) begin
    if (arr_write_en) mem[arr_write_addr] <= arr_write_val;
  end

  assign arr_read_val = '0;

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; n = '0; in_valid = 1'b1; in_data = 32'h55;
    tick(); tick();
    #1;
    vectors++;
    if (in_ready !== 1'b0 || finish !== 1'b0 || arr_write_en !== 1'b0 || res !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: in_ready=%b finish=%b wen=%b res=%0h, need 0 0 0 0",
               in_ready, finish, arr_write_en, res);
    end
    vectors++;
    if (arr_read_en !== 1'b0 || arr_read_addr !== 10'd0 || arr_clk !== clk) begin
      miscompares++;
      $display("FAIL tied_ports: ren=%b raddr=%0d arr_clk=%b clk=%b, need 0 0 and arr_clk==clk",
               arr_read_en, arr_read_addr, arr_clk, clk);
    end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [DW-1:0] d [4];
    d[0] = 32'd10; d[1] = 32'd20; d[2] = 32'd30; d[3] = 32'd40;
    start = 1'b1; n = 10'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = d[i];
      #1;
      vectors++;
      if (in_ready !== 1'b1 || arr_write_en !== 1'b1 || arr_write_addr !== 10'(i) ||
          arr_write_val !== d[i] || finish !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_write%0d: rdy=%b wen=%b addr=%0d val=%0d fin=%b, need 1 1 %0d %0d 0",
                 i, in_ready, arr_write_en, arr_write_addr, arr_write_val, finish, i, d[i]);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    vectors++;
    if (finish !== 1'b1 || res !== 32'd100 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_finish: fin=%b res=%0d rdy=%b, need 1 100 0", finish, res, in_ready);
    end
    tick();
    vectors++;
    if (finish !== 1'b0 || res !== 32'd100) begin
      miscompares++;
      $display("FAIL basic_after: fin=%b res=%0d, need 0 100", finish, res);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (mem[i] !== d[i]) begin
        miscompares++;
        $display("FAIL basic_readback%0d: got %0d need %0d", i, mem[i], d[i]);
      end
    end
  endtask

  task automatic test_stalls();
    bit [5:0] pat;
    int       wr;
    pat = 6'b101001;  // cycle 1..6: 1,0,0,1,0,1
    wr  = 0;
    start = 1'b1; n = 10'd3;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i]; in_data = 32'(100 + i);
      #1;
      vectors++;
      if (arr_write_en !== pat[i] || finish !== 1'b0 || in_ready !== 1'b1 ||
          (pat[i] && (arr_write_addr !== 10'(wr) || arr_write_val !== 32'(100 + i)))) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: wen=%b addr=%0d val=%0d fin=%b rdy=%b, need wen=%b addr=%0d",
                 i + 1, arr_write_en, arr_write_addr, arr_write_val, finish, in_ready, pat[i], wr);
      end
      if (pat[i]) wr++;
      tick();
    end
    in_valid = 1'b0;
    #1;
    vectors++;
    if (finish !== 1'b1 || res !== 32'd308 || arr_write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_finish: fin=%b res=%0d wen=%b, need 1 308 0", finish, res, arr_write_en);
    end
    tick();
  endtask

  task automatic test_zero();
    start = 1'b1; n = 10'd0; in_valid = 1'b1; in_data = 32'hDEAD;
    #1;
    vectors++;
    if (arr_write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_idle_wen: got %b need 0", arr_write_en);
    end
    tick();
    start = 1'b0;
    #1;
    vectors++;
    if (finish !== 1'b1 || arr_write_en !== 1'b0 || res !== 32'd0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_finish: fin=%b wen=%b res=%0h rdy=%b, need 1 0 0 0",
               finish, arr_write_en, res, in_ready);
    end
    tick();
    vectors++;
    if (finish !== 1'b0 || arr_write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_after: fin=%b wen=%b, need 0 0", finish, arr_write_en);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap_ignore_start();
    start = 1'b1; n = 10'd2;
    tick();
    // start stays high and n changes while WRITE is running
    start = 1'b1; n = 10'd7;
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    #1;
    vectors++;
    if (arr_write_en !== 1'b1 || arr_write_addr !== 10'd0) begin
      miscompares++;
      $display("FAIL wrap_addr0: wen=%b addr=%0d, need 1 0", arr_write_en, arr_write_addr);
    end
    tick();
    start = 1'b0;
    in_data = 32'h0000_0002;
    #1;
    vectors++;
    if (arr_write_en !== 1'b1 || arr_write_addr !== 10'd1) begin
      miscompares++;
      $display("FAIL wrap_addr1: wen=%b addr=%0d, need 1 1", arr_write_en, arr_write_addr);
    end
    tick();
    #1;
    vectors++;
    if (finish !== 1'b1 || res !== 32'h0000_0001 || arr_write_en !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_res: fin=%b res=%0h wen=%b, need 1 1 0", finish, res, arr_write_en);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    start = 1'b1; n = 10'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'hA1;
    tick();
    in_data = 32'hA2;
    tick();
    in_data = 32'hA3;
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b0 || arr_write_en !== 1'b0 || finish !== 1'b0 || res !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_async: rdy=%b wen=%b fin=%b res=%0h, need 0 0 0 0",
               in_ready, arr_write_en, finish, res);
    end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1; n = 10'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'd7;
    #1;
    vectors++;
    if (arr_write_en !== 1'b1 || arr_write_addr !== 10'd0 || arr_write_val !== 32'd7) begin
      miscompares++;
      $display("FAIL midreset_refill: wen=%b addr=%0d val=%0d, need 1 0 7",
               arr_write_en, arr_write_addr, arr_write_val);
    end
    tick();
    in_valid = 1'b0;
    #1;
    vectors++;
    if (finish !== 1'b1 || res !== 32'd7) begin
      miscompares++;
      $display("FAIL midreset_res: fin=%b res=%0d, need 1 7", finish, res);
    end
    vectors++;
    if (mem[0] !== 32'd7 || mem[1] !== 32'hA2) begin
      miscompares++;
      $display("FAIL midreset_kept: mem0=%0h mem1=%0h, need 7 a2", mem[0], mem[1]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_sum;
    logic [DW-1:0] rd_sum;
    logic [DW-1:0] w;
    start = 1'b1; n = 10'd1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 32'd9;
    tick();
    in_valid = 1'b0;
    #1;
    vectors++;
    if (finish !== 1'b1 || res !== 32'd9) begin
      miscompares++;
      $display("FAIL b2b_first: fin=%b res=%0d, need 1 9", finish, res);
    end
    tick();
    // IDLE cycle directly after the finish pulse
    start = 1'b1; n = 10'd1023;
    #1;
    vectors++;
    if (in_ready !== 1'b0 || finish !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: rdy=%b fin=%b, need 0 0", in_ready, finish);
    end
    tick();
    start = 1'b0;
    exp_sum = '0;
    for (int i = 0; i < 1023; i++) begin
      w = 32'(i * 7 + 3) ^ 32'hF000_0000;
      in_valid = 1'b1; in_data = w;
      exp_sum = exp_sum + w;
      #1;
      vectors++;
      if (in_ready !== 1'b1 || arr_write_en !== 1'b1 || arr_write_addr !== 10'(i) ||
          arr_write_val !== w || finish !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_write%0d: rdy=%b wen=%b addr=%0d fin=%b, need 1 1 %0d 0",
                 i, in_ready, arr_write_en, arr_write_addr, finish, i);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    vectors++;
    if (finish !== 1'b1 || res !== exp_sum) begin
      miscompares++;
      $display("FAIL b2b_finish: fin=%b res=%0h, need 1 %0h", finish, res, exp_sum);
    end
    tick();
    vectors++;
    if (finish !== 1'b0 || in_ready !== 1'b0 || res !== exp_sum) begin
      miscompares++;
      $display("FAIL b2b_after: fin=%b rdy=%b res=%0h, need 0 0 %0h", finish, in_ready, res, exp_sum);
    end
    rd_sum = '0;
    for (int i = 0; i < 1023; i++) rd_sum = rd_sum + mem[i];
    vectors++;
    if (rd_sum !== res) begin
      miscompares++;
      $display("FAIL b2b_readback_sum: array sum=%0h res=%0h", rd_sum, res);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic();
    test_stalls();
    test_zero();
    test_wrap_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
